axil_line_cache: RTL and testbench
==================================

// Module: axil_line_cache
// PURPOSE
//   Direct-mapped, write-through, no-write-allocate cache with one 32-bit CPU word port.
//   It is an AXI-Lite-4 master with 128-bit data, fetching and writing whole 16-byte lines.
//   Two instances serve as the CPU I-cache and D-cache. Both connect through the 2-master AXI-Lite mux to the shared SRAM slave.
// PARAMETERS
//   LINES   64  number of lines; power of 2; index = address[4+$clog2(LINES)-1:4]
//   ADDR_W  16  CPU address width; tag = address[ADDR_W-1:4+$clog2(LINES)]
// PORTS
//   clk              in  1    clock, all logic on rising edge
//   rst              in  1    reset, asynchronous, active-low
//   r_en             in  1    read request, held until ready
//   w_en             in  4    byte-enable write request, held until ready; nonzero = write
//   address          in  16   byte address; [3:2] word offset, [1:0] ignored
//   write_data       in  32   store data
//   read_data        out 32   load data, valid while ready=1 for a read
//   ready            out 1    request complete
//   readAddr_addr    out 32   line address {16'b0,address[15:4],4'b0}
//   readAddr_valid / readAddr_ready     out/in 1   AR handshake
//   readData_data    in  128  refill line, byte i = bits[8i+7:8i]
//   readData_valid / readData_ready     in/out 1   R handshake
//   writeAddr_addr   out 32   line address, same format as readAddr_addr
//   writeAddr_valid / writeAddr_ready   out/in 1   AW handshake
//   writeData_data   out 128  write_data replicated into all four word lanes
//   writeData_strb   out 16   w_en << (4*address[3:2])
//   writeData_valid / writeData_ready   out/in 1   W handshake
//   writeResp_msg    in  32   response code, ignored
//   writeResp_valid / writeResp_ready   in/out 1   B handshake
// BEHAVIOUR
//   Reset: all valid bits cleared; FSM=IDLE. All *_valid, *_ready, ready and read_data are 0.
//   Hit test: valid[idx] && tag[idx]==tag(address).
//   States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, WR_DONE.
//   IDLE, read hit (w_en==0, r_en=1): ready=1 combinationally in the same cycle.
//     read_data = the addressed word of the line. Zero latency.
//   IDLE, read miss: go to RD_ADDR.
//     - readAddr_valid=1 and stays set until readAddr_ready; address held stable.
//     - Then RD_DATA: readData_ready=1. On readData_valid, write data, tag and valid=1 into the line.
//     - Return to IDLE. The request hits on the next cycle, so a miss costs (bus latency + 2) cycles.
//   IDLE, w_en!=0: a write has priority over a simultaneous r_en.
//     - On a hit, update the enabled bytes of the line on entry; on a miss, leave the line unchanged.
//     - WR_ADDR: writeAddr_valid and writeData_valid both assert. Each drops independently once its ready is seen.
//     - When both handshakes are done, go to WR_RESP with writeResp_ready=1. On writeResp_valid, go to WR_DONE.
//     - WR_DONE: ready=1 for exactly 1 cycle, then IDLE.
//   Request dropped mid-transaction: the AXI transaction still completes and the refill is still installed.
//     ready is not asserted for the dropped request.
//   r_en=0 and w_en=0: stay in IDLE; no bus activity; ready=0.
//   Async reset mid-transaction: abort immediately; all outputs go to their reset values.
// CONFIGURATION
//   CACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
//     - Each counts IDLE-cycle request decisions; a write miss counts as a miss.
//     - A miss counts once, not on the follow-up hit. Both counters clear on reset and wrap at 2^32.
//   Not defined: these ports and counters do not exist.
// STRUCTURE
//   Package axil_cache_pkg: state enum, LINE_BYTES=16, OFFSET_W=4, AXI_DATA_W=128, AXI_ADDR_W=32.
//   Sub-module cache_line_store: valid/tag/data arrays. Combinational read, byte-masked write.
//     Line fill and store-hit merge happen on the same write port.
// TESTING
//   1 Reset, then r_en=1 at 0x0000 with SRAM line 0 = {..,0x00000013} -> one AR at 0x0; ready=1; read_data=0x00000013.
//   2 Repeat read at 0x0004 -> ready in the same cycle; no AR issued; read_data = word 1 of line 0.
//   3 I-cache reads 0x0010 while D-cache reads 0x0020 -> both caches get the correct lines through the mux; each ready asserts once.
//   4 w_en=4'b0011, address=0x0028, write_data=0xAABBCCDD -> AW addr=0x20; strb=0x0300; WR_DONE ready pulses 1 cycle.
//     A reread of 0x0028 then returns 0xXXXXCCDD from the cache with no AR.
//   5 Read 0x0000, then read 0x0400 (same index, different tag) -> the second read misses and refills; a reread of 0x0000 misses again.
//   6 Assert rst during RD_DATA -> all outputs go to 0 at once; the next read of the same line misses.

Source files
------------

// File: rtl/axil_cache_pkg.sv
// Shared sizes, state encoding and strobe helper for the AXI-Lite line cache.
package axil_cache_pkg;

   localparam int unsigned LINE_BYTES = 16;
   localparam int unsigned OFFSET_W   = 4;
   localparam int unsigned AXI_DATA_W = 128;
   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned WORD_W     = 32;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_RESP,
      WR_DONE
   } cacheState_e;

   // Place a word's byte enables on its lane within the line.
   function automatic logic [LINE_BYTES-1:0] lineStrb(input logic [3:0] wEn, input logic [1:0] word);
      return LINE_BYTES'(wEn) << {word, 2'b00};
   endfunction

endpackage

// File: rtl/axil_line_cache_if.sv
// AXI-Lite 128-bit line bus between a line cache (master) and memory (slave).
interface axil_line_cache_if;
   import axil_cache_pkg::*;

   logic [AXI_ADDR_W-1:0] readAddr_addr;
   logic                  readAddr_valid;
   logic                  readAddr_ready;
   logic [AXI_DATA_W-1:0] readData_data;
   logic                  readData_valid;
   logic                  readData_ready;
   logic [AXI_ADDR_W-1:0] writeAddr_addr;
   logic                  writeAddr_valid;
   logic                  writeAddr_ready;
   logic [AXI_DATA_W-1:0] writeData_data;
   logic [LINE_BYTES-1:0] writeData_strb;
   logic                  writeData_valid;
   logic                  writeData_ready;
   logic [31:0]           writeResp_msg;
   logic                  writeResp_valid;
   logic                  writeResp_ready;

   modport master (
      output readAddr_addr, readAddr_valid, input readAddr_ready,
      input  readData_data, readData_valid, output readData_ready,
      output writeAddr_addr, writeAddr_valid, input writeAddr_ready,
      output writeData_data, writeData_strb, writeData_valid, input writeData_ready,
      input  writeResp_msg, writeResp_valid, output writeResp_ready
   );

   modport slave (
      input  readAddr_addr, readAddr_valid, output readAddr_ready,
      output readData_data, readData_valid, input readData_ready,
      input  writeAddr_addr, writeAddr_valid, output writeAddr_ready,
      input  writeData_data, writeData_strb, writeData_valid, output writeData_ready,
      output writeResp_msg, writeResp_valid, input writeResp_ready
   );

endinterface

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: combinational read, one byte-masked write port
// shared by line refill and store-hit merge.
module cache_line_store
   import axil_cache_pkg::*;
#(
   parameter int unsigned LINES = 64,
   parameter int unsigned TAG_W = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(LINES)-1:0] rdIdx,
   output logic                     rdValid,
   output logic [TAG_W-1:0]         rdTag,
   output logic [AXI_DATA_W-1:0]    rdData,
   input  logic                     we,
   input  logic [$clog2(LINES)-1:0] wrIdx,
   input  logic [TAG_W-1:0]         wrTag,
   input  logic [AXI_DATA_W-1:0]    wrData,
   input  logic [LINE_BYTES-1:0]    wrMask
);

   logic [LINES-1:0]      validQ;
   logic [TAG_W-1:0]      tagMem  [LINES];
   logic [AXI_DATA_W-1:0] dataMem [LINES];

   assign rdValid = validQ[rdIdx];
   assign rdTag   = tagMem[rdIdx];
   assign rdData  = dataMem[rdIdx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) validQ <= '0;
      else if (we) validQ[wrIdx] <= 1'b1;
   end

   // Tag and data carry no reset; validQ alone decides whether they mean anything.
   always_ff @(posedge clk) begin
      if (we) begin
         tagMem[wrIdx] <= wrTag;
         for (int b = 0; b < LINE_BYTES; b++) begin
            if (wrMask[b]) dataMem[wrIdx][8*b +: 8] <= wrData[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/axil_line_cache.sv
// Direct-mapped, write-through, no-write-allocate line cache with an AXI-Lite line bus.
// Define CACHE_STATS_EN to add the hit_count / miss_count outputs.
module axil_line_cache
   import axil_cache_pkg::*;
#(
   parameter int unsigned LINES  = 64,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r_en,
   input  logic [3:0]        w_en,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              ready,
   axil_line_cache_if.master bus
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W;

   cacheState_e           state;
   logic [IDX_W-1:0]      idx, fillIdx, wrIdx;
   logic [TAG_W-1:0]      tag, fillTag, lineTag, wrTag;
   logic [AXI_DATA_W-1:0] lineData, wrData;
   logic [LINE_BYTES-1:0] wrMask;
   logic [AXI_ADDR_W-1:0] lineAddr;
   logic                  lineValid, hit, isWrite, readHit, storeWe, filling;
   logic                  unusedBits;

   assign idx      = address[OFFSET_W +: IDX_W];
   assign tag      = address[ADDR_W-1 -: TAG_W];
   assign lineAddr = {{(AXI_ADDR_W-ADDR_W){1'b0}}, address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   assign hit      = lineValid && (lineTag == tag);
   assign isWrite  = |w_en;
   assign readHit  = (state == IDLE) && !isWrite && r_en && hit;
   assign unusedBits = ^{address[1:0], bus.writeResp_msg};

   // Zero-latency hit path; a write completes only while its request is still held.
   assign ready     = readHit || ((state == WR_DONE) && isWrite);
   assign read_data = readHit ? lineData[{address[3:2], 5'd0} +: WORD_W] : '0;

   // Refill uses the latched miss line; a store hit merges at the live address.
   assign filling = (state == RD_DATA) && bus.readData_valid;
   assign storeWe = filling || ((state == IDLE) && isWrite && hit);
   assign wrIdx   = filling ? fillIdx : idx;
   assign wrTag   = filling ? fillTag : tag;
   assign wrData  = filling ? bus.readData_data : {4{write_data}};
   assign wrMask  = filling ? '1 : lineStrb(w_en, address[3:2]);

   cache_line_store #(.LINES(LINES), .TAG_W(TAG_W)) u_store (
      .clk    (clk),
      .rst    (rst),
      .rdIdx  (idx),
      .rdValid(lineValid),
      .rdTag  (lineTag),
      .rdData (lineData),
      .we     (storeWe),
      .wrIdx  (wrIdx),
      .wrTag  (wrTag),
      .wrData (wrData),
      .wrMask (wrMask)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         fillIdx             <= '0;
         fillTag             <= '0;
         bus.readAddr_addr   <= '0;
         bus.readAddr_valid  <= 1'b0;
         bus.readData_ready  <= 1'b0;
         bus.writeAddr_addr  <= '0;
         bus.writeAddr_valid <= 1'b0;
         bus.writeData_data  <= '0;
         bus.writeData_strb  <= '0;
         bus.writeData_valid <= 1'b0;
         bus.writeResp_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (isWrite) begin
                  bus.writeAddr_addr  <= lineAddr;
                  bus.writeData_data  <= {4{write_data}};
                  bus.writeData_strb  <= lineStrb(w_en, address[3:2]);
                  bus.writeAddr_valid <= 1'b1;
                  bus.writeData_valid <= 1'b1;
                  state               <= WR_ADDR;
               end else if (r_en && !hit) begin
                  bus.readAddr_addr  <= lineAddr;
                  bus.readAddr_valid <= 1'b1;
                  fillIdx            <= idx;
                  fillTag            <= tag;
                  state              <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               if (bus.readAddr_ready) begin
                  bus.readAddr_valid <= 1'b0;
                  bus.readData_ready <= 1'b1;
                  state              <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (bus.readData_valid) begin
                  bus.readData_ready <= 1'b0;
                  state              <= IDLE;
               end
            end
            WR_ADDR: begin
               if (bus.writeAddr_ready) bus.writeAddr_valid <= 1'b0;
               if (bus.writeData_ready) bus.writeData_valid <= 1'b0;
               if ((!bus.writeAddr_valid || bus.writeAddr_ready) &&
                   (!bus.writeData_valid || bus.writeData_ready)) begin
                  bus.writeResp_ready <= 1'b1;
                  state               <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (bus.writeResp_valid) begin
                  bus.writeResp_ready <= 1'b0;
                  state               <= WR_DONE;
               end
            end
            WR_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic justFilled;

   // The hit that follows a refill belongs to the miss already counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count  <= '0;
         miss_count <= '0;
         justFilled <= 1'b0;
      end else begin
         if (filling) justFilled <= 1'b1;
         else if (state == IDLE) justFilled <= 1'b0;
         if ((state == IDLE) && (isWrite || r_en)) begin
            if (!hit) miss_count <= miss_count + 32'd1;
            else if (isWrite || !justFilled) hit_count <= hit_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axil_line_cache.sv
// Randomized bench for axil_line_cache: AXI-Lite memory slave plus a
// word-level reference memory and valid/tag presence model.
module tb_axil_line_cache;
   import axil_cache_pkg::*;

   localparam int LIMIT = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_en;
   logic [3:0]  w_en;
   logic [15:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
`ifdef CACHE_STATS_EN
   logic [31:0] hitCount, missCount;
`endif

   axil_line_cache_if bus();

   axil_line_cache #(.LINES(64), .ADDR_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .r_en      (r_en),
      .w_en      (w_en),
      .address   (address),
      .write_data(write_data),
      .read_data (read_data),
      .ready     (ready),
      .bus       (bus)
`ifdef CACHE_STATS_EN
      ,
      .hit_count (hitCount),
      .miss_count(missCount)
`endif
   );

   always #5 clk = ~clk;

   int          checkCount = 0;
   int          errorCount = 0;
   logic [31:0] sramMem [16384];
   logic [31:0] refMem  [16384];
   bit          mValid  [64];
   logic [5:0]  mTag    [64];
   int          arCount = 0, awCount = 0, wCount = 0, bCount = 0;
   logic [31:0] lastAr, lastAw;
   logic [127:0] lastWData;
   logic [15:0] lastWStrb;
   int          rExtra = 0;
   int          expHits = 0, expMisses = 0;
   logic [31:0] lastRead;
   bit          lastHit;

   function automatic logic [31:0] memInit(input int unsigned w);
      return (w == 0) ? 32'h0000_0013 : 32'(w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [37:0] outsVec();
      return {bus.readAddr_valid, bus.readData_ready, bus.writeAddr_valid,
              bus.writeData_valid, bus.writeResp_ready, ready, read_data};
   endfunction

   task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Read slave: AR then a whole line from sramMem.
   initial begin
      int n;
      bus.readAddr_ready = 1'b0;
      bus.readData_valid = 1'b0;
      bus.readData_data  = '0;
      forever begin
         @(negedge clk);
         if (rst && bus.readAddr_valid) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.readAddr_ready = 1'b1;
            lastAr = bus.readAddr_addr;
            arCount++;
            @(negedge clk);
            bus.readAddr_ready = 1'b0;
            repeat (rExtra + int'($urandom_range(0, 2))) @(negedge clk);
            for (int w = 0; w < 4; w++) bus.readData_data[32*w +: 32] = sramMem[{lastAr[15:4], 2'(w)}];
            bus.readData_valid = 1'b1;
            n = 0;
            while (rst && !bus.readData_ready && n < LIMIT) begin @(negedge clk); n++; end
            @(negedge clk);
            bus.readData_valid = 1'b0;
         end
      end
   end

   initial begin
      bus.writeAddr_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && bus.writeAddr_valid) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.writeAddr_ready = 1'b1;
            lastAw = bus.writeAddr_addr;
            awCount++;
            @(negedge clk);
            bus.writeAddr_ready = 1'b0;
         end
      end
   end

   initial begin
      bus.writeData_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && bus.writeData_valid) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.writeData_ready = 1'b1;
            lastWData = bus.writeData_data;
            lastWStrb = bus.writeData_strb;
            wCount++;
            @(negedge clk);
            bus.writeData_ready = 1'b0;
         end
      end
   end

   // Response slave also owns the memory contents.
   initial begin
      int n;
      for (int i = 0; i < 16384; i++) sramMem[i] = memInit(i);
      bus.writeResp_valid = 1'b0;
      bus.writeResp_msg   = '0;
      forever begin
         @(negedge clk);
         if (awCount > bCount && wCount > bCount) begin
            for (int b = 0; b < 16; b++)
               if (lastWStrb[b]) sramMem[{lastAw[15:4], 2'(b / 4)}][8*(b % 4) +: 8] = lastWData[8*b +: 8];
            bCount++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.writeResp_valid = 1'b1;
            n = 0;
            while (rst && !bus.writeResp_ready && n < LIMIT) begin @(negedge clk); n++; end
            @(negedge clk);
            bus.writeResp_valid = 1'b0;
         end
      end
   end

   task automatic doRead(input logic [15:0] a);
      logic [5:0]  li, lt;
      bit          expHit;
      logic [31:0] expWord;
      int          arBefore, cyc;
      li = a[9:4];
      lt = a[15:10];
      expHit  = mValid[li] && (mTag[li] == lt);
      expWord = refMem[a[15:2]];
      arBefore = arCount;
      @(negedge clk);
      address = a; w_en = 4'b0; r_en = 1'b1;
      cyc = 0;
      #1;
      while (!ready && cyc < LIMIT) begin @(negedge clk); #1; cyc++; end
      checkVal("rd_done", 128'(cyc < LIMIT), 128'(1));
      lastRead = read_data;
      lastHit  = (cyc == 0);
      checkVal("rd_data", 128'(read_data), 128'(expWord));
      checkVal("rd_hit", 128'(lastHit), 128'(expHit));
      checkVal("rd_ar_count", 128'(arCount - arBefore), 128'(expHit ? 0 : 1));
      if (!expHit) checkVal("rd_ar_addr", 128'(lastAr), 128'({a[15:4], 4'h0}));
      @(posedge clk); #1;
      r_en = 1'b0;
      mValid[li] = 1'b1;
      mTag[li]   = lt;
      if (expHit) expHits++; else expMisses++;
   endtask

   task automatic doWrite(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d);
      logic [5:0]  li, lt;
      bit          expHit;
      logic [15:0] expStrb;
      int          awBefore, wBefore, cyc;
      li = a[9:4];
      lt = a[15:10];
      expHit   = mValid[li] && (mTag[li] == lt);
      expStrb  = 16'(we) << (4 * int'(a[3:2]));
      awBefore = awCount;
      wBefore  = wCount;
      @(negedge clk);
      address = a; w_en = we; write_data = d; r_en = 1'($urandom_range(0, 1));
      cyc = 0;
      #1;
      while (!ready && cyc < LIMIT) begin @(negedge clk); #1; cyc++; end
      checkVal("wr_done", 128'(cyc < LIMIT), 128'(1));
      checkVal("wr_aw_count", 128'(awCount - awBefore), 128'(1));
      checkVal("wr_w_count", 128'(wCount - wBefore), 128'(1));
      checkVal("wr_aw_addr", 128'(lastAw), 128'({a[15:4], 4'h0}));
      checkVal("wr_strb", 128'(lastWStrb), 128'(expStrb));
      checkVal("wr_data", lastWData, {4{d}});
      @(posedge clk); #1;
      checkVal("wr_ready_pulse", 128'(ready), 128'(0));
      w_en = 4'b0; r_en = 1'b0;
      for (int b = 0; b < 4; b++) if (we[b]) refMem[a[15:2]][8*b +: 8] = d[8*b +: 8];
      if (expHit) expHits++; else expMisses++;
   endtask

   initial begin
      logic [15:0] a;
      int n;
      r_en = 1'b0; w_en = 4'b0; address = '0; write_data = '0;
      for (int i = 0; i < 16384; i++) refMem[i] = memInit(i);
      for (int i = 0; i < 64; i++) begin mValid[i] = 1'b0; mTag[i] = '0; end
      rst = 1'b0;
      #1;
      checkVal("reset_outs", 128'(outsVec()), 128'(0));
      repeat (3) @(negedge clk);
      rst = 1'b1;

      doRead(16'h0000);
      checkVal("t1_word0", 128'(lastRead), 128'(32'h0000_0013));
      checkVal("t1_miss", 128'(lastHit), 128'(0));
      doRead(16'h0004);
      checkVal("t2_hit", 128'(lastHit), 128'(1));

      doRead(16'h0020);
      doWrite(16'h0028, 4'b0011, 32'hAABB_CCDD);
      checkVal("t4_aw", 128'(lastAw), 128'(32'h20));
      checkVal("t4_strb", 128'(lastWStrb), 128'(16'h0300));
      doRead(16'h0028);
      checkVal("t4_reread", 128'(lastRead[15:0]), 128'(16'hCCDD));
      checkVal("t4_no_ar", 128'(lastHit), 128'(1));

      doWrite(16'h0434, 4'b1111, 32'h1234_5678);
      doRead(16'h0434);
      checkVal("wmiss_no_alloc", 128'(lastHit), 128'(0));

      doRead(16'h0000);
      doRead(16'h0400);
      checkVal("t5_conflict_miss", 128'(lastHit), 128'(0));
      doRead(16'h0000);
      checkVal("t5_reread_miss", 128'(lastHit), 128'(0));

      // Reset while the refill is outstanding.
      @(negedge clk);
      rExtra = 6;
      address = 16'h0050; r_en = 1'b1;
      n = 0;
      #1;
      while (!bus.readData_ready && n < LIMIT) begin @(negedge clk); #1; n++; end
      checkVal("t6_reach_rd_data", 128'(n < LIMIT), 128'(1));
      rst = 1'b0;
      #1;
      checkVal("t6_reset_outs", 128'(outsVec()), 128'(0));
      r_en = 1'b0;
      for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
      expHits = 0; expMisses = 0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      rExtra = 0;
      doRead(16'h0050);
      checkVal("t6_miss_after_reset", 128'(lastHit), 128'(0));
      doRead(16'h0000);
      checkVal("t6_line0_cleared", 128'(lastHit), 128'(0));

      for (int k = 0; k < 300; k++) begin
         a = 16'($urandom_range(0, 3) * 1024 + $urandom_range(0, 7) * 16 + $urandom_range(0, 15));
         if ($urandom_range(0, 9) < 3) doWrite(a, 4'($urandom_range(1, 15)), $urandom);
         else doRead(a);
      end

`ifdef CACHE_STATS_EN
      checkVal("stat_hits", 128'(hitCount), 128'(expHits));
      checkVal("stat_misses", 128'(missCount), 128'(expMisses));
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
